// File: rtl/smg_pkg.sv
// Shared types and helpers for the multi-digit seven-segment scan controller:
// segment type, hex-to-segment table and the output polarity helper.
package smg_pkg;

    typedef logic [7:0] seg_t;  // {dp,g,f,e,d,c,b,a}, active-high internally

    localparam seg_t SEG_BLANK = 8'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic seg_t apply_seg_pol(input seg_t seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/smg_seg_decode.sv
// Combinational hex nibble + decimal point to active-high segment pattern.
module smg_seg_decode
    import smg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output seg_t       seg_o
);

    assign seg_o = {dp_i, hex_to_seg(nibble_i)};

endmodule

// File: rtl/smg_scan_multi.sv
// Multi-digit seven-segment scan controller: frame-synchronous load, leading-zero
// blanking, PWM dimming and dead-time between digit slots, registered outputs.
module smg_scan_multi
    import smg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int DEAD_CYC       = 2,
    parameter int DIM_BITS       = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic                    lz_blank,
    input  logic                    load,
    input  logic [DIM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   column_scan_signal,
    output logic [7:0]              row_scan_signal,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int SLOT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int IDX_N  = 1 << IDX_W;

    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0]     SLOT_DEAD = SLOT_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] COL_INV   = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};
    localparam bit                    SEG_LOW   = (SEG_ACTIVE_LOW != 0);

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DIM_BITS-1:0]     pwm_q;
    logic [4*NUM_DIGITS-1:0] stage_data_q, shad_data_q;
    logic [NUM_DIGITS-1:0]   stage_dp_q, shad_dp_q;
    logic                    stage_lz_q, shad_lz_q;
    logic                    pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   col_q, col_d;
    seg_t                    row_q, seg_d, dec_seg;
    logic                    frame_done_q;

    logic                    slot_wrap, frame_wrap, pwm_on, col_act;
    logic [3:0]              nib_arr [IDX_N];
    logic [IDX_N-1:0]        dp_vec;
    logic [IDX_N-1:0]        blank_vec;
    logic                    blank_run;

    // ---------------- scan timing ----------------
    assign slot_wrap  = (slot_q >= SLOT_LAST);
    assign frame_wrap = slot_wrap && (idx_q >= IDX_LAST);

    always_comb begin
        slot_d = slot_wrap ? '0 : slot_q + SLOT_W'(1);
        idx_d  = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q >= IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else if (idx_q > IDX_LAST) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_q + DIM_BITS'(1);
            frame_done_q <= frame_wrap;
        end
    end

    // ---------------- staging / shadow ----------------
    // Pending data is only applied at the frame wrap; a load on that same cycle
    // refreshes staging and keeps pending set for the following frame.
    always_comb begin
        pending_d = pending_q;
        if (load) begin
            pending_d = 1'b1;
        end else if (frame_wrap) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_data_q <= '0;
            stage_dp_q   <= '0;
            stage_lz_q   <= 1'b0;
            shad_data_q  <= '0;
            shad_dp_q    <= '0;
            shad_lz_q    <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            if (frame_wrap && pending_q) begin
                shad_data_q <= stage_data_q;
                shad_dp_q   <= stage_dp_q;
                shad_lz_q   <= stage_lz_q;
            end
            if (load) begin
                stage_data_q <= digit_data;
                stage_dp_q   <= dp_en;
                stage_lz_q   <= lz_blank;
            end
            pending_q <= pending_d;
        end
    end

    // ---------------- digit mux and blanking ----------------
    for (genvar gi = 0; gi < IDX_N; gi++) begin : g_digit
        if (gi < NUM_DIGITS) begin : g_real
            assign nib_arr[gi] = shad_data_q[4*gi +: 4];
            assign dp_vec[gi]  = shad_dp_q[gi];
        end else begin : g_pad
            assign nib_arr[gi] = 4'h0;
            assign dp_vec[gi]  = 1'b0;
        end
    end

    // A digit is blanked while it and every digit above it are zero with no dp.
    always_comb begin
        blank_vec = '0;
        blank_run = shad_lz_q;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            blank_run    = blank_run && (shad_data_q[4*i +: 4] == 4'h0) && !shad_dp_q[i];
            blank_vec[i] = blank_run;
        end
    end

    smg_seg_decode u_decode (
        .nibble_i (nib_arr[idx_q]),
        .dp_i     (dp_vec[idx_q]),
        .seg_o    (dec_seg)
    );

    // ---------------- output stage ----------------
    assign pwm_on  = (pwm_q < brightness) || (&brightness);
    assign col_act = (slot_q >= SLOT_DEAD) && pwm_on && !blank_vec[idx_q];

    always_comb begin
        col_d = col_act ? (NUM_DIGITS'(1) << idx_q) : '0;
        seg_d = blank_vec[idx_q] ? SEG_BLANK : dec_seg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= COL_INV;
            row_q <= apply_seg_pol(SEG_BLANK, SEG_LOW);
        end else begin
            col_q <= col_d ^ COL_INV;
            row_q <= apply_seg_pol(seg_d, SEG_LOW);
        end
    end

    assign column_scan_signal = col_q;
    assign row_scan_signal    = row_q;
    assign frame_done         = frame_done_q;
    assign busy               = pending_q;

endmodule

// File: tb/tb_smg_scan_multi.sv
// Self-checking bench for smg_scan_multi: directed scenarios plus random loads,
// every cycle compared against a frame/slot arithmetic reference model.
module tb_smg_scan_multi;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int DC = 2;
    localparam int DB = 4;
    localparam int FRAME = ND * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digit_data = '0;
    logic [3:0]  dp_en = '0;
    logic        lz_blank = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic [3:0]  column_scan_signal;
    logic [7:0]  row_scan_signal;
    logic        frame_done;
    logic        busy;

    smg_scan_multi #(
        .NUM_DIGITS     (ND),
        .CLK_DIV        (CD),
        .DEAD_CYC       (DC),
        .DIM_BITS       (DB),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .digit_data         (digit_data),
        .dp_en              (dp_en),
        .lz_blank           (lz_blank),
        .load               (load),
        .brightness         (brightness),
        .column_scan_signal (column_scan_signal),
        .row_scan_signal    (row_scan_signal),
        .frame_done         (frame_done),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          m_n;          // clock edges since reset release
    logic [15:0] sh_data, st_data;
    logic [3:0]  sh_dp, st_dp;
    logic        sh_lz, st_lz, pend;
    logic [3:0]  exp_col;
    logic [7:0]  exp_row;
    logic        exp_fd, exp_busy;
    logic [7:0]  prev_row = 8'hFF;
    int          last_fd;
    int          act_cnt;

    task automatic model_reset();
        m_n = 0;
        sh_data = '0; st_data = '0; sh_dp = '0; st_dp = '0;
        sh_lz = 1'b0; st_lz = 1'b0; pend = 1'b0;
        exp_col = 4'hF; exp_row = 8'hFF; exp_fd = 1'b0; exp_busy = 1'b0;
        last_fd = -1;
    endtask

    // Outputs after an edge show the display for the state held before that edge.
    task automatic model_edge();
        int s, slot, idx, pwm;
        logic [3:0] nib;
        bit blank, lit;
        s    = m_n;
        slot = s % CD;
        idx  = (s / CD) % ND;
        pwm  = s % 16;
        nib  = 4'((sh_data >> (4 * idx)) & 16'hF);
        blank = sh_lz && (idx != 0) && ((sh_data >> (4 * idx)) == 0) && ((sh_dp >> idx) == 0);
        lit   = (pwm < int'(brightness)) || (brightness == 4'hF);
        exp_row = blank ? 8'hFF : ~{sh_dp[idx], seg_tab[nib]};
        exp_col = (slot >= DC && lit && !blank) ? ~(4'b0001 << idx) : 4'hF;
        exp_fd  = (s % FRAME) == FRAME - 1;
        if (exp_fd && pend) begin
            sh_data = st_data; sh_dp = st_dp; sh_lz = st_lz; pend = 1'b0;
        end
        if (load) begin
            st_data = digit_data; st_dp = dp_en; st_lz = lz_blank; pend = 1'b1;
        end
        exp_busy = pend;
        m_n++;
    endtask

    task automatic check_outputs();
        check("col", 32'(column_scan_signal), 32'(exp_col));
        check("row", 32'(row_scan_signal), 32'(exp_row));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        check("busy", 32'(busy), 32'(exp_busy));
        if (row_scan_signal !== prev_row)
            check("deadtime_col", 32'(column_scan_signal), 32'hF);
        prev_row = row_scan_signal;
        if (frame_done === 1'b1) begin
            if (last_fd >= 0) check("fd_period", 32'(m_n - last_fd), 32'(FRAME));
            last_fd = m_n;
        end
        if (column_scan_signal !== 4'hF) act_cnt++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic align_to(input int phase);
        for (int k = 0; k < 2 * FRAME && (m_n % FRAME) != phase; k++) cyc();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        digit_data = d; dp_en = dp; lz_blank = lz; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    function automatic int dim_expect(input int b);
        int c = 0;
        for (int p = 0; p < 16; p++) if (p < b && (p % CD) >= DC) c++;
        return c * (16 * CD / 16);
    endfunction

    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1);
    end

    initial begin
        do_reset();
        repeat (5) cyc();

        // Basic scan of 1234 at full brightness
        do_load(16'h1234, 4'h0, 1'b0);
        repeat (3 * FRAME) cyc();

        // Mid-scan reset then resume
        align_to(13);
        do_reset();
        do_load(16'h1234, 4'h0, 1'b0);
        repeat (2 * FRAME) cyc();

        // Brightness: dark, then partial duty over 16 slots
        foreach (masks[k]) if (k < 3) begin
            brightness = (k == 0) ? 4'h0 : ((k == 1) ? 4'h4 : 4'h9);
            act_cnt = 0;
            repeat (16 * CD) cyc();
            check("dim_active", 32'(act_cnt), 32'(dim_expect(int'(brightness))));
        end
        brightness = 4'hF;

        // Leading-zero blanking, without and with a decimal point on digit 2
        do_load(16'h0050, 4'h0, 1'b1);
        repeat (2 * FRAME) cyc();
        do_load(16'h0050, 4'b0100, 1'b1);
        repeat (2 * FRAME) cyc();

        // Back-to-back loads before the wrap: last one wins
        align_to(5);
        do_load(16'hAAAA, 4'h0, 1'b0);
        do_load(16'hBBBB, 4'h0, 1'b0);
        repeat (2 * FRAME) cyc();

        // Load exactly on the wrap cycle applies one frame later
        align_to(FRAME - 1);
        do_load(16'hCCCC, 4'h0, 1'b0);
        repeat (2 * FRAME) cyc();

        // Random loads, brightness and blanking, with one reset in the middle
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            if ($urandom_range(0, 199) == 0) brightness = 4'($urandom);
            digit_data = 16'($urandom) & masks[$urandom_range(0, 4)];
            dp_en      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            lz_blank   = 1'($urandom);
            load       = ($urandom_range(0, 23) == 0);
            cyc();
        end
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
